// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: sequential PC fetch with one outstanding memory request,
// a small FIFO of fetched words toward decode, and redirect with in-flight drop.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] Instruction,
  output logic [63:0] inst_pc,
  output logic [1:0]  fetch_state
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DROP = 2'd3} state_t;

  state_t        state;
  logic [63:0]   pc;
  logic [63:0]   tag;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   buf_data [0:BUF_DEPTH-1];
  logic [63:0]   buf_pc   [0:BUF_DEPTH-1];
  logic          push;
  logic          pop;
  logic          has_room;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a producer holds valid and its payload steady until that edge.
  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign fetch_state    = state;

  assign inst_valid  = (count != '0);
  assign Instruction = inst_valid ? buf_data[rd_ptr] : 32'h0;
  assign inst_pc     = inst_valid ? buf_pc[rd_ptr] : 64'h0;

  assign push = (state == WAIT) && imem_rsp_valid;
  assign pop  = inst_valid && inst_ready;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (!push && pop) begin
      count_next = count - 1'b1;
    end
  end

  // A new request is only issued while a slot is free, so the response always has room.
  assign has_room = (count_next < CW'(BUF_DEPTH));

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      tag    <= '0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      // Any request already accepted by memory must have its response swallowed.
      case (state)
        WAIT, DROP: state <= imem_rsp_valid ? REQ : DROP;
        REQ:        state <= imem_req_ready ? DROP : REQ;
        default:    state <= REQ;
      endcase
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= imem_rsp_data;
        buf_pc[wr_ptr]   <= tag;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count_next;
      case (state)
        IDLE: begin
          if (count < CW'(BUF_DEPTH)) state <= REQ;
        end
        REQ: begin
          if (imem_req_ready) begin
            state <= WAIT;
            tag   <= pc;
            pc    <= pc + 64'd4;
          end
        end
        WAIT, DROP: begin
          if (imem_rsp_valid) state <= has_room ? REQ : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: 1-cycle memory model, scoreboard of expected
// fetch PCs, a table of redirect/fetch vectors and hand-written corner sequences.
module tb_instruction_fetch_unit;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] Instruction;
  logic [63:0] inst_pc;
  logic [1:0]  fetch_state;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic        mem_en = 1'b1;
  logic        mon_en = 1'b1;
  logic        mem_hs = 1'b0;
  logic [63:0] mem_addr = 64'h0;

  typedef struct {
    logic [63:0] target;
    int          n;
    int          rdy_pct;
    int          mem_pct;
  } vec_t;

  vec_t vecs[5];

  instruction_fetch_unit #(.RESET_PC(64'h0), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .Instruction    (Instruction),
    .inst_pc        (inst_pc),
    .fetch_state    (fetch_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory: a request accepted on one edge is answered during the following cycle.
  always @(negedge clk) begin
    mem_hs   = mem_en && imem_req_valid && imem_req_ready;
    mem_addr = imem_req_addr;
  end

  always @(posedge clk) begin
    #2;
    if (mem_en) begin
      imem_rsp_valid = mem_hs;
      imem_rsp_data  = mem_hs ? word(mem_addr) : 32'h0;
    end
  end

  // Scoreboard: every consumed instruction must be the next expected PC and its word.
  always @(negedge clk) begin
    if (mon_en && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", inst_pc, 64'hDEAD);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("pop_pc", inst_pc, e);
        chk("pop_word", {32'h0, Instruction}, {32'h0, word(e)});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_run(input logic [63:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 64'(4 * i));
  endtask

  task automatic drain(input int rdy_pct, input int mem_pct, input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      tick();
      inst_ready     = (exp_q.size() != 0) && ($urandom_range(0, 99) < rdy_pct);
      imem_req_ready = ($urandom_range(0, 99) < mem_pct);
      @(negedge clk);
      #1;
      c++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'h0);
    exp_q.delete();
    tick();
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget);
    int c;
    c = 0;
    @(negedge clk);
    while (fetch_state != s && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("wait_state", {62'h0, fetch_state}, {62'h0, s});
  endtask

  task automatic redirect_to(input logic [63:0] t);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = t;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    inst_ready     = 1'b0;

    vecs[0] = '{64'h1000, 6, 100, 100};
    vecs[1] = '{64'h2000, 5, 50, 100};
    vecs[2] = '{64'h3000, 5, 100, 40};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFF8, 4, 70, 70};
    vecs[4] = '{64'h40, 8, 30, 60};

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("rst_req_addr", imem_req_addr, 64'h0);
    chk("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
    chk("rst_instruction", {32'h0, Instruction}, 64'h0);
    chk("rst_inst_pc", inst_pc, 64'h0);
    chk("rst_state", {62'h0, fetch_state}, {62'h0, S_IDLE});

    // First-instruction latency: valid after the third edge with reset high
    tick();
    imem_req_ready = 1'b1;
    reset          = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("latency_not_yet", {63'h0, inst_valid}, 64'h0);
    @(posedge clk);
    @(negedge clk);
    chk("latency_valid", {63'h0, inst_valid}, 64'h1);
    chk("latency_pc", inst_pc, 64'h0);
    chk("latency_word", {32'h0, Instruction}, {32'h0, word(64'h0)});

    // Decode stalled: fetch stops with the buffer full and PC parked at 8
    repeat (10) @(negedge clk);
    chk("stall_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("stall_pc", imem_req_addr, 64'h8);
    chk("stall_state", {62'h0, fetch_state}, {62'h0, S_IDLE});
    chk("stall_head", inst_pc, 64'h0);
    expect_run(64'h0, 4);
    drain(100, 100, 100);

    // Table of redirect targets with varying consumer/memory back-pressure
    foreach (vecs[i]) begin
      redirect_to(vecs[i].target);
      @(negedge clk);
      chk("vec_flush", {63'h0, inst_valid}, 64'h0);
      expect_run(vecs[i].target, vecs[i].n);
      drain(vecs[i].rdy_pct, vecs[i].mem_pct, 300);
    end

    // Request held while memory is not ready
    wait_state(S_IDLE, 50);
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {63'h0, imem_req_valid}, 64'h1);
      chk("hold_addr", imem_req_addr, 64'h200);
    end
    expect_run(64'h200, 2);
    drain(100, 100, 100);

    // Redirect while waiting on 0x10: its response must be dropped
    wait_state(S_IDLE, 50);
    mem_en         = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_to(64'h10);
    @(posedge clk);
    @(negedge clk);
    chk("drop_in_wait", {62'h0, fetch_state}, {62'h0, S_WAIT});
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    tick();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word(64'h10);
    @(negedge clk);
    chk("drop_state", {62'h0, fetch_state}, {62'h0, S_DROP});
    tick();
    imem_rsp_valid = 1'b0;
    mem_en         = 1'b1;
    @(negedge clk);
    chk("drop_after_state", {62'h0, fetch_state}, {62'h0, S_REQ});
    chk("drop_after_addr", imem_req_addr, 64'h100);
    chk("drop_after_valid", {63'h0, inst_valid}, 64'h0);
    expect_run(64'h100, 2);
    drain(100, 100, 100);

    // Redirect on the same edge as a push and a pop
    wait_state(S_IDLE, 50);
    redirect_to(64'h500);
    repeat (2) tick();
    tick();
    mon_en         = 1'b0;
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h600;
    @(negedge clk);
    chk("full_pre_state", {62'h0, fetch_state}, {62'h0, S_WAIT});
    chk("full_pre_head", inst_pc, 64'h500);
    chk("full_pre_rsp", {63'h0, imem_rsp_valid}, 64'h1);
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    mon_en         = 1'b1;
    @(negedge clk);
    chk("full_flush_valid", {63'h0, inst_valid}, 64'h0);
    chk("full_flush_state", {62'h0, fetch_state}, {62'h0, S_REQ});
    chk("full_flush_addr", imem_req_addr, 64'h600);
    expect_run(64'h600, 2);
    drain(100, 100, 100);

    // Reset in WAIT, stale response arrives the cycle after
    wait_state(S_IDLE, 50);
    mem_en         = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_to(64'h300);
    @(posedge clk);
    @(negedge clk);
    chk("rst_wait_state", {62'h0, fetch_state}, {62'h0, S_WAIT});
    tick();
    reset = 1'b0;
    tick();
    reset          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word(64'h300);
    @(negedge clk);
    chk("rst_mid_state", {62'h0, fetch_state}, {62'h0, S_IDLE});
    chk("rst_mid_addr", imem_req_addr, 64'h0);
    tick();
    imem_rsp_valid = 1'b0;
    mem_en         = 1'b1;
    @(negedge clk);
    chk("rst_stale_valid", {63'h0, inst_valid}, 64'h0);
    chk("rst_stale_state", {62'h0, fetch_state}, {62'h0, S_REQ});
    expect_run(64'h0, 2);
    drain(100, 100, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
